// File: rtl/regfile_reader_pkg.sv
// Shared definitions for the register-file dump streamer.
// Holds the FSM state codes and the index constants used by the top
// level and by the testbench.
package regfile_reader_pkg;

    localparam int unsigned INDEX_W  = 4;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned FLAG_W   = 4;

    // Index of the last register word and of the optional trailing flags word
    localparam logic [INDEX_W-1:0] LAST_REG    = 4'd7;
    localparam logic [INDEX_W-1:0] FLAGS_INDEX = 4'd8;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0000,
        ST_SEND  = 4'b0001,
        ST_FLAGS = 4'b0010,
        ST_DONE  = 4'b0011
    } state_e;

endpackage : regfile_reader_pkg

// File: rtl/regfile_reader_reg_select_mux.sv
// reg_select_mux: 8:1 word selector over the register snapshot.
// Ports:
//   i_data  in  8 x WIDTH  snapshot words R0..R7
//   i_sel   in  3          word select (low bits of the stream index)
//   o_data  out WIDTH      selected word (combinational)
module reg_select_mux
    import regfile_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data [NUM_REGS],
    input  logic [SEL_W-1:0] i_sel,
    output logic [WIDTH-1:0] o_data
);

    // Pure selection; no state lives here
    always_comb begin
        o_data = i_data[i_sel];
    end

endmodule : reg_select_mux

// File: rtl/regfile_reader.sv
// regfile_reader: snapshots R0..R7 and the V/C/N/Z flags on a start request
// and streams them out one word per accepted valid/ready transfer.
// Ports:
//   Clk        in   1      rising-edge clock
//   Reset      in   1      synchronous active-high reset
//   start      in   1      dump request, honoured only in IDLE
//   R0..R7     in   WIDTH  live register file contents
//   V,C,N,Z    in   1      live status flags
//   out_ready  in   1      consumer accepts the current word
//   out_valid  out  1      Data_out holds a valid word
//   Data_out   out  WIDTH  streamed word
//   index      out  4      0..7 register number, 8 flags word
//   busy       out  1      dump in progress (SEND/FLAGS/DONE)
//   done       out  1      one-cycle pulse after the last word is accepted
//   state      out  4      current FSM state code
module regfile_reader
    import regfile_reader_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          SEND_FLAGS = 1'b1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   R0,
    input  logic [WIDTH-1:0]   R1,
    input  logic [WIDTH-1:0]   R2,
    input  logic [WIDTH-1:0]   R3,
    input  logic [WIDTH-1:0]   R4,
    input  logic [WIDTH-1:0]   R5,
    input  logic [WIDTH-1:0]   R6,
    input  logic [WIDTH-1:0]   R7,
    input  logic               V,
    input  logic               C,
    input  logic               N,
    input  logic               Z,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   Data_out,
    output logic [INDEX_W-1:0] index,
    output logic               busy,
    output logic               done,
    output logic [3:0]         state
);

    state_e               r_state;
    state_e               w_next_state;
    logic [INDEX_W-1:0]   r_index;
    logic [INDEX_W-1:0]   w_next_index;
    logic                 w_capture;
    logic [WIDTH-1:0]     r_snap [NUM_REGS];
    logic [FLAG_W-1:0]    r_flags;
    logic [WIDTH-1:0]     w_mux_data;

    reg_select_mux #(
        .WIDTH (WIDTH)
    ) u_reg_select_mux (
        .i_data (r_snap),
        .i_sel  (r_index[SEL_W-1:0]),
        .o_data (w_mux_data)
    );

    // State, index and snapshot registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_index <= '0;
            r_flags <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            r_index <= w_next_index;
            if (w_capture) begin
                r_snap[0] <= R0;
                r_snap[1] <= R1;
                r_snap[2] <= R2;
                r_snap[3] <= R3;
                r_snap[4] <= R4;
                r_snap[5] <= R5;
                r_snap[6] <= R6;
                r_snap[7] <= R7;
                r_flags   <= {V, C, N, Z};
            end
        end
    end

    // Next-state and output decode; a transfer is out_ready while in SEND/FLAGS
    always_comb begin
        w_next_state = r_state;
        w_next_index = r_index;
        w_capture    = 1'b0;
        out_valid    = 1'b0;
        Data_out     = '0;
        busy         = 1'b1;
        done         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_capture    = 1'b1;
                    w_next_index = '0;
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                out_valid = 1'b1;
                Data_out  = w_mux_data;
                if (out_ready) begin
                    if (r_index == LAST_REG) begin
                        if (SEND_FLAGS) begin
                            w_next_index = FLAGS_INDEX;
                            w_next_state = ST_FLAGS;
                        end else begin
                            w_next_state = ST_DONE;
                        end
                    end else begin
                        w_next_index = r_index + INDEX_W'(1);
                    end
                end
            end
            ST_FLAGS: begin
                out_valid = 1'b1;
                Data_out  = {{(WIDTH - FLAG_W){1'b0}}, r_flags};
                if (out_ready) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_index = '0;
                w_next_state = ST_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_next_index = '0;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign index = r_index;
    assign state = r_state;

endmodule : regfile_reader

// File: tb/tb_regfile_reader.sv
// Directed testbench for regfile_reader: full dumps, back-pressure, snapshot
// isolation, ignored start, mid-dump reset, and a build without the flags word.
module tb_regfile_reader;
    import regfile_reader_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       start;
    logic       start_nf;
    logic [7:0] r_in [8];
    logic       V, C, N, Z;
    logic       out_ready;

    logic       out_valid, busy, done;
    logic [7:0] Data_out;
    logic [3:0] index, state;

    logic       nf_valid, nf_busy, nf_done;
    logic [7:0] nf_data;
    logic [3:0] nf_index, nf_state;

    int n_total = 0;
    int n_bad   = 0;

    always #5 Clk = ~Clk;

    regfile_reader #(.WIDTH(8), .SEND_FLAGS(1'b1)) dut (
        .Clk(Clk), .Reset(Reset), .start(start),
        .R0(r_in[0]), .R1(r_in[1]), .R2(r_in[2]), .R3(r_in[3]),
        .R4(r_in[4]), .R5(r_in[5]), .R6(r_in[6]), .R7(r_in[7]),
        .V(V), .C(C), .N(N), .Z(Z), .out_ready(out_ready),
        .out_valid(out_valid), .Data_out(Data_out), .index(index),
        .busy(busy), .done(done), .state(state)
    );

    regfile_reader #(.WIDTH(8), .SEND_FLAGS(1'b0)) dut_nf (
        .Clk(Clk), .Reset(Reset), .start(start_nf),
        .R0(r_in[0]), .R1(r_in[1]), .R2(r_in[2]), .R3(r_in[3]),
        .R4(r_in[4]), .R5(r_in[5]), .R6(r_in[6]), .R7(r_in[7]),
        .V(V), .C(C), .N(N), .Z(Z), .out_ready(out_ready),
        .out_valid(nf_valid), .Data_out(nf_data), .index(nf_index),
        .busy(nf_busy), .done(nf_done), .state(nf_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Hand-computed stream: 11,22,..,88 then the VCNZ=1010 flags word
    function automatic logic [7:0] exp_word(input int k);
        logic [7:0] w;
        case (k)
            0: w = 8'h11;  1: w = 8'h22;  2: w = 8'h33;  3: w = 8'h44;
            4: w = 8'h55;  5: w = 8'h66;  6: w = 8'h77;  7: w = 8'h88;
            default: w = 8'h0A;
        endcase
        return w;
    endfunction

    task automatic load_regs();
        for (int i = 0; i < 8; i++) r_in[i] = 8'((i + 1) * 8'h11);
        {V, C, N, Z} = 4'b1010;
    endtask

    // Full-rate dump with optional R3 overwrite and a stray start at index 4
    task automatic stream(input string tag, input bit chg_r3, input bit poke);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (chg_r3 && k == 1) r_in[3] = 8'hFF;
            start = (poke && k == 4);
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_index"}, 32'(index), 32'(k));
            chk({tag, "_data"},  32'(Data_out), 32'(exp_word(k)));
            tick();
        end
        start = 1'b0;
        chk({tag, "_done"},      32'(done), 32'd1);
        chk({tag, "_done_nval"}, 32'(out_valid), 32'd0);
        chk({tag, "_done_busy"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_idle_state"}, 32'(state), 32'(ST_IDLE));
        chk({tag, "_idle_done"},  32'(done), 32'd0);
        chk({tag, "_idle_busy"},  32'(busy), 32'd0);
        tick();
        chk({tag, "_no_restart"}, 32'(state), 32'(ST_IDLE));
    endtask

    initial begin
        int count;
        Reset = 1'b1; start = 1'b0; start_nf = 1'b0; out_ready = 1'b0;
        load_regs();
        tick();
        tick();
        chk("rst_state", 32'(state), 32'(ST_IDLE));
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(Data_out), 32'd0);
        chk("rst_index", 32'(index), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        Reset = 1'b0;
        tick();

        // 1: full-rate dump
        stream("t1", 1'b0, 1'b0);

        // 2: ready pattern 1,0,0,1,... ; words must hold while ready is low
        start = 1'b1;
        tick();
        start = 1'b0;
        count = 0;
        for (int cyc = 0; cyc < 200 && count < 9; cyc++) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            chk("t2_valid", 32'(out_valid), 32'd1);
            chk("t2_index", 32'(index), 32'(count));
            chk("t2_data",  32'(Data_out), 32'(exp_word(count)));
            if (out_ready) count++;
            tick();
        end
        out_ready = 1'b1;
        chk("t2_xfers", 32'(count), 32'd9);
        chk("t2_done",  32'(done), 32'd1);
        tick();
        chk("t2_idle", 32'(state), 32'(ST_IDLE));

        // 3: live R3 change after start is not seen in the stream
        stream("t3", 1'b1, 1'b0);
        load_regs();

        // 4: start during SEND is ignored, single done pulse
        stream("t4", 1'b0, 1'b1);

        // 5: reset at index 5 aborts, next dump starts from R0
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("t5_at5", 32'(index), 32'd5);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("t5_state", 32'(state), 32'(ST_IDLE));
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_done",  32'(done), 32'd0);
        chk("t5_index", 32'(index), 32'd0);
        stream("t5r", 1'b0, 1'b0);

        // 6: SEND_FLAGS=0 build: 8 words, done right after R7
        out_ready = 1'b1;
        start_nf = 1'b1;
        tick();
        start_nf = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("t6_valid", 32'(nf_valid), 32'd1);
            chk("t6_index", 32'(nf_index), 32'(k));
            chk("t6_data",  32'(nf_data), 32'(exp_word(k)));
            tick();
        end
        chk("t6_done",    32'(nf_done), 32'd1);
        chk("t6_nval",    32'(nf_valid), 32'd0);
        chk("t6_not8",    32'(nf_index == 4'd8), 32'd0);
        tick();
        chk("t6_idle",    32'(nf_state), 32'(ST_IDLE));
        chk("t6_idle_dn", 32'(nf_done), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_regfile_reader
